uart_tx_sched: RTL

Round-robin scheduler that shares one UART transmitter between NumReq byte sources. Each source uses a valid/ready handshake. The scheduler accepts one byte at a time and issues it to the transmitter as a single-cycle valid pulse. It then blocks further grants for a fixed frame time plus an inter-frame gap, because the transmitter has no ready/busy output. It sits between firmware-facing peripherals (console, debug, log streams) and the single uart_tx instance.

---
 rtl/uart_tx_sched.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_sched
// Purpose  : Round-robin scheduler sharing one UART transmitter between
//            several byte sources, pacing grants by a fixed frame + gap time.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_sched #(
    parameter int NUM_REQ        = 2,
    parameter int TICKS_PER_BAUD = 0,
    parameter int FRAME_CYCLES   = 10 * TICKS_PER_BAUD,
    parameter int GAP_CYCLES     = 0,
    localparam int GRANT_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [8*NUM_REQ-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic [7:0]             tx_data_o,
    output logic                   tx_valid_o,
    output logic                   busy_o,
    output logic [GRANT_W-1:0]     grant_o
);

    // Clamp so a degenerate parameter set still yields a legal one-cycle wait.
    localparam int C_TOTAL   = (FRAME_CYCLES + GAP_CYCLES > 1) ? (FRAME_CYCLES + GAP_CYCLES) : 1;
    localparam int C_TIMER_W = $clog2(C_TOTAL + 1);
    localparam logic [C_TIMER_W-1:0] C_TIMER_LOAD = C_TIMER_W'(C_TOTAL - 1);
    localparam logic [GRANT_W-1:0]   C_LAST_IDX   = GRANT_W'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [C_TIMER_W-1:0]   r_timer;
    logic [GRANT_W-1:0]     r_ptr;
    logic [GRANT_W-1:0]     r_grant;
    logic [7:0]             r_tx_data;
    logic                   r_tx_valid;
    logic                   r_busy;

    logic                   w_found;
    logic [GRANT_W-1:0]     w_sel;
    logic [NUM_REQ-1:0]     w_sel_onehot;
    logic [7:0]             w_sel_data;
    logic                   w_accept;
    logic [NUM_REQ-1:0]     w_ready;
    logic [GRANT_W-1:0]     w_ptr_next;

    // Scan from the farthest offset down so the nearest valid to r_ptr wins.
    always_comb begin
        int j;
        w_found      = 1'b0;
        w_sel        = '0;
        w_sel_onehot = '0;
        w_sel_data   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = int'(r_ptr) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (req_valid_i[j]) begin
                w_found      = 1'b1;
                w_sel        = GRANT_W'(j);
                w_sel_onehot = '0;
                w_sel_onehot[j] = 1'b1;
                w_sel_data   = req_data_i[8*j +: 8];
            end
        end
    end

    assign w_ptr_next = (w_sel == C_LAST_IDX) ? '0 : (w_sel + 1'b1);

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_ready      = '0;
        case (r_state)
            ST_IDLE: begin
                if (!rst_i && w_found) begin
                    w_accept     = 1'b1;
                    w_ready      = w_sel_onehot;
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_timer == '0) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_timer    <= '0;
            r_ptr      <= '0;
            r_grant    <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_tx_valid <= w_accept;
            if (w_accept) begin
                r_tx_data <= w_sel_data;
                r_grant   <= w_sel;
                r_ptr     <= w_ptr_next;
                r_timer   <= C_TIMER_LOAD;
                r_busy    <= 1'b1;
            end else if (r_state == ST_WAIT) begin
                if (r_timer == '0) begin
                    r_busy <= 1'b0;
                end else begin
                    r_timer <= r_timer - 1'b1;
                end
            end
        end
    end

    assign req_ready_o = w_ready;
    assign tx_data_o   = r_tx_data;
    assign tx_valid_o  = r_tx_valid;
    assign busy_o      = r_busy;
    assign grant_o     = r_grant;

endmodule
`default_nettype wire
